// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing for the FiFo burst reader and its skid buffer.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        FLUSH    = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 3;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    function automatic logic [SKID_PTR_W-1:0] skid_next_ptr(input logic [SKID_PTR_W-1:0] ptr);
        return (ptr == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : SKID_PTR_W'(ptr + 1'b1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Three-entry data+last buffer; the head entry drives the downstream stream.
module fifo_burst_reader_skid
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [SKID_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] data_mem [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] last_mem;
    logic [SKID_PTR_W-1:0] wr_ptr;
    logic [SKID_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count != SKID_CNT_W'(SKID_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) data_mem[i] <= '0;
            last_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                data_mem[wr_ptr] <= push_data;
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= skid_next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= skid_next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= SKID_CNT_W'(count + 1'b1);
                2'b01:   count <= SKID_CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_last = last_mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains LENGTH words from a FiFo read port onto a valid/ready stream with a last marker.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [LEN_WIDTH-1:0]  LENGTH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  FIFO_nRE,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    input  logic                  FIFO_EMPTY,
    output logic                  O_VALID,
    input  logic                  O_READY,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  O_LAST
);

    state_t                state;
    state_t                next_state;
    logic [LEN_WIDTH-1:0]  issue_remaining;
    logic                  inflight;
    logic                  inflight_last;
    logic                  pop;
    logic                  accept;
    logic                  final_pop;
    logic                  head_last;
    logic [SKID_CNT_W-1:0] skid_count;

    // Pop decision uses registered state only, so O_READY never reaches FIFO_nRE.
    assign pop = (state == ISSUE) && !FIFO_EMPTY && (issue_remaining != '0) &&
                 ((3'(skid_count) + 3'(inflight)) < 3'(SKID_DEPTH));
    assign final_pop = pop && (issue_remaining == LEN_WIDTH'(1));
    assign accept    = O_VALID && O_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (START) next_state = (LENGTH == '0) ? COMPLETE : ISSUE;
            ISSUE:    if (final_pop) next_state = FLUSH;
            FLUSH:    if (accept && O_LAST) next_state = COMPLETE;
            COMPLETE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        DONE     = (state == COMPLETE);
        FIFO_nRE = !pop;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUSY            <= 1'b0;
            issue_remaining <= '0;
            inflight        <= 1'b0;
            inflight_last   <= 1'b0;
        end else begin
            BUSY          <= (next_state != IDLE);
            inflight      <= pop;
            inflight_last <= final_pop;
            if (state == IDLE && START)
                issue_remaining <= LENGTH;
            else if (pop && issue_remaining != '0)
                issue_remaining <= LEN_WIDTH'(issue_remaining - 1'b1);
        end
    end

    fifo_burst_reader_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (CLK),
        .rst       (RST),
        .push      (inflight),
        .push_data (FIFO_DOUT),
        .push_last (inflight_last),
        .pop       (accept),
        .head_data (O_DATA),
        .head_last (head_last),
        .count     (skid_count)
    );

    assign O_VALID = (skid_count != '0);
    assign O_LAST  = O_VALID && head_last;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bench for fifo_burst_reader against a FiFo model and word scoreboard.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic [LW-1:0] LENGTH = '0;
    logic          BUSY, DONE, FIFO_nRE, FIFO_EMPTY, O_VALID, O_LAST;
    logic [DW-1:0] FIFO_DOUT = '0;
    logic          O_READY = 1'b1;
    logic [DW-1:0] O_DATA;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LENGTH(LENGTH), .BUSY(BUSY), .DONE(DONE),
        .FIFO_nRE(FIFO_nRE), .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY),
        .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA), .O_LAST(O_LAST)
    );

    always #5 CLK = ~CLK;

    // FiFo model: registered read data, valid the cycle after a pop.
    logic [DW-1:0] fifo_mem [0:511];
    int            load_cnt = 0;
    int            pop_cnt = 0;
    logic          gate_empty = 1'b0;
    assign FIFO_EMPTY = gate_empty || (pop_cnt >= load_cnt);

    always @(posedge CLK) begin
        if (!FIFO_nRE && pop_cnt < load_cnt) begin
            FIFO_DOUT <= fifo_mem[pop_cnt];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    int            pops_seen = 0;
    int            done_seen = 0;
    int            accepted = 0;
    int            rdy_mode = 0;
    int            emp_mode = 0;
    int            cyc = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [DW-1:0] w);
        fifo_mem[load_cnt] = w;
        load_cnt++;
    endtask

    // Per-cycle protocol and scoreboard checks, taken at the falling edge.
    task automatic sample();
        @(negedge CLK);
        if (!FIFO_nRE) begin
            pops_seen++;
            chk("pop_while_empty", 64'(FIFO_EMPTY), 64'(0));
        end
        if (prev_hold) begin
            chk("hold_valid", 64'(O_VALID), 64'(1));
            chk("hold_data", 64'(O_DATA), 64'(prev_data));
            chk("hold_last", 64'(O_LAST), 64'(prev_last));
        end
        if (O_VALID && O_READY) begin
            chk("word_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                chk("data", 64'(O_DATA), 64'(exp_q[0]));
                chk("last", 64'(O_LAST), 64'(exp_q.size() == 1));
                exp_q.delete(0);
                accepted++;
            end
        end
        if (DONE) done_seen++;
        prev_hold = O_VALID && !O_READY;
        prev_data = O_DATA;
        prev_last = O_LAST;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        case (rdy_mode)
            0:       O_READY = 1'b1;
            1:       O_READY = ($urandom_range(0, 1) == 1);
            default: O_READY = 1'b0;
        endcase
        case (emp_mode)
            0:       gate_empty = 1'b0;
            1:       gate_empty = (((cyc / 2) % 2) != 0);
            default: gate_empty = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    task automatic start_burst(input int len);
        START  = 1'b1;
        LENGTH = LW'(len);
        for (int i = 0; i < len; i++) exp_q.push_back(fifo_mem[pop_cnt + i]);
        sample();
        step();
        START = 1'b0;
    endtask

    task automatic run_until_done(input int bound, input string tag);
        bit found = 1'b0;
        for (int n = 0; n < bound && !found; n++) begin
            sample();
            if (DONE) found = 1'b1;
            step();
        end
        chk({tag, "_done_seen"}, 64'(found), 64'(1));
        chk({tag, "_words_left"}, 64'(exp_q.size()), 64'(0));
        sample();
        chk({tag, "_busy_after"}, 64'(BUSY), 64'(0));
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(BUSY), 64'(0));
        chk({tag, "_done"}, 64'(DONE), 64'(0));
        chk({tag, "_nre"}, 64'(FIFO_nRE), 64'(1));
        chk({tag, "_valid"}, 64'(O_VALID), 64'(0));
        chk({tag, "_data"}, 64'(O_DATA), 64'(0));
        chk({tag, "_last"}, 64'(O_LAST), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        int len;

        // Reset held for three cycles, then idle with no START.
        #2 RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_reset_outputs("reset");
            step();
        end
        RST = 1'b0;
        pops_seen = 0;
        for (int i = 0; i < 5; i++) begin sample(); step(); end
        chk("idle_no_pops", 64'(pops_seen), 64'(0));

        // LENGTH=4 full-rate burst with cycle-exact timing.
        for (int i = 0; i < 4; i++) load_word(DW'(32'h10 + i));
        pops_seen = 0;
        done_seen = 0;
        start_burst(4);
        for (int k = 1; k <= 9; k++) begin
            sample();
            chk("l4_nre", 64'(FIFO_nRE), 64'(!(k >= 1 && k <= 4)));
            chk("l4_valid", 64'(O_VALID), 64'(k >= 3 && k <= 6));
            chk("l4_done", 64'(DONE), 64'(k == 7));
            chk("l4_busy", 64'(BUSY), 64'(k <= 7));
            step();
        end
        chk("l4_words_left", 64'(exp_q.size()), 64'(0));
        chk("l4_pops", 64'(pops_seen), 64'(4));

        // Backpressure: only three pops before the skid fills.
        for (int i = 0; i < 6; i++) load_word(DW'($urandom));
        rdy_mode = 2;
        O_READY = 1'b0;
        pops_seen = 0;
        start_burst(6);
        for (int k = 1; k <= 10; k++) begin sample(); step(); end
        chk("bp_pops_stalled", 64'(pops_seen), 64'(3));
        rdy_mode = 0;
        O_READY = 1'b1;
        run_until_done(40, "bp");
        chk("bp_pops_total", 64'(pops_seen), 64'(6));

        // FIFO_EMPTY toggling every two cycles.
        for (int i = 0; i < 5; i++) load_word(DW'($urandom));
        emp_mode = 1;
        start_burst(5);
        run_until_done(60, "empty_toggle");
        emp_mode = 0;
        gate_empty = 1'b0;

        // Zero-length burst: a DONE pulse and nothing else.
        pops_seen = 0;
        done_seen = 0;
        start_burst(0);
        for (int k = 1; k <= 4; k++) begin sample(); step(); end
        chk("zero_done_count", 64'(done_seen), 64'(1));
        chk("zero_pops", 64'(pops_seen), 64'(0));

        // START while busy must be ignored.
        for (int i = 0; i < 10; i++) load_word(DW'($urandom));
        pops_seen = 0;
        done_seen = 0;
        start_burst(3);
        sample();
        step();
        START  = 1'b1;
        LENGTH = LW'(7);
        sample();
        step();
        START = 1'b0;
        run_until_done(30, "busy_start");
        for (int k = 0; k < 6; k++) begin sample(); step(); end
        chk("busy_start_pops", 64'(pops_seen), 64'(3));
        chk("busy_start_dones", 64'(done_seen), 64'(1));

        // Reset mid-burst after two accepted words, then a clean LENGTH=3 burst.
        for (int i = 0; i < 8; i++) load_word(DW'($urandom));
        accepted = 0;
        reached = 1'b0;
        start_burst(5);
        for (int n = 0; n < 20 && !reached; n++) begin
            sample();
            if (accepted >= 2) reached = 1'b1;
            step();
        end
        chk("rst_two_accepted", 64'(reached), 64'(1));
        RST = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        prev_hold = 1'b0;
        sample();
        step();
        RST = 1'b0;
        sample();
        step();
        pops_seen = 0;
        start_burst(3);
        run_until_done(30, "post_reset");
        chk("post_reset_pops", 64'(pops_seen), 64'(3));

        // Randomized bursts with random backpressure and empty gaps.
        rdy_mode = 1;
        emp_mode = 2;
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) load_word(DW'($urandom));
            pops_seen = 0;
            start_burst(len);
            run_until_done(400, "rand");
            chk("rand_pops", 64'(pops_seen), 64'(len));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
